// File: rtl/avl_mem_arbiter.sv
// avl_mem_arbiter
// Round-robin arbiter that funnels N level-held CPU read/write requests onto a
// single Avalon-MM port of the LPDDR2 controller. Only one transaction is in
// flight at a time. Reads that never return data are recovered by a timeout.
//
// Ports:
//   external_clk       single clock (controller half-rate domain)
//   rst                synchronous reset, active-high
//   init_done          controller calibration done; no new grant while low
//   p_rreq / p_wreq    per-port read / write request, held until p_ack
//   p_addr / p_wdata   per-port byte address and write data, packed by port
//   p_rdata            read data, valid in the ack cycle of a read
//   p_ack              one-hot, one-cycle completion pulse
//   avl_*              Avalon-MM master towards the controller
//   timeout_err        sticky read-timeout flag, cleared only by rst
//   state              FSM state for debug display
module avl_mem_arbiter #(
    parameter int N_PORTS    = 2,
    parameter int CPU_ADDR_W = 32,
    parameter int AVL_ADDR_W = 27,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                         external_clk,
    input  logic                         rst,
    input  logic                         init_done,
    input  logic [N_PORTS-1:0]           p_rreq,
    input  logic [N_PORTS-1:0]           p_wreq,
    input  logic [N_PORTS*CPU_ADDR_W-1:0] p_addr,
    input  logic [N_PORTS*DATA_W-1:0]    p_wdata,
    output logic [DATA_W-1:0]            p_rdata,
    output logic [N_PORTS-1:0]           p_ack,
    input  logic                         avl_waitrequest_n,
    output logic [AVL_ADDR_W-1:0]        avl_address,
    output logic [DATA_W-1:0]            avl_writedata,
    output logic                         avl_read,
    output logic                         avl_write,
    output logic                         avl_burstbegin,
    input  logic                         avl_readdatavalid,
    input  logic [DATA_W-1:0]            avl_readdata,
    output logic                         timeout_err,
    output logic [1:0]                   state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_RD = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF);

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        grant_q, grant_d;
    logic [AVL_ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    is_wr_q, is_wr_d;
    logic                    cmd_q, cmd_d;
    logic                    burst_q, burst_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    terr_q, terr_d;

    logic                    arb_found;
    logic [PTR_W-1:0]        arb_pick;
    logic [PTR_W:0]          arb_idx;

    // Round-robin search: first requesting port at or after the pointer,
    // wrapping from the last port back to port 0.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        arb_idx   = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            arb_idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (arb_idx >= (PTR_W+1)'(N_PORTS)) begin
                arb_idx = arb_idx - (PTR_W+1)'(N_PORTS);
            end
            if (!arb_found && (p_rreq[arb_idx[PTR_W-1:0]] || p_wreq[arb_idx[PTR_W-1:0]])) begin
                arb_found = 1'b1;
                arb_pick  = arb_idx[PTR_W-1:0];
            end
        end
    end

    // Next-state and datapath updates. The Avalon command outputs are
    // registered, so the first ISSUE cycle only loads them; the controller
    // sees the command (with burstbegin) from the second ISSUE cycle on and
    // waitrequest_n is only honoured while the command is actually visible.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        cmd_d   = cmd_q;
        burst_d = 1'b0;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;

        case (state_q)
            S_IDLE: begin
                if (init_done && arb_found) begin
                    grant_d = arb_pick;
                    addr_d  = p_addr[int'(arb_pick)*CPU_ADDR_W + 2 +: AVL_ADDR_W];
                    wdata_d = p_wdata[int'(arb_pick)*DATA_W +: DATA_W];
                    // A write wins when both requests are up on the granted port.
                    is_wr_d = p_wreq[arb_pick];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!cmd_q) begin
                    cmd_d   = 1'b1;
                    burst_d = 1'b1;
                end else if (avl_waitrequest_n) begin
                    cmd_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = is_wr_q ? S_DONE : S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                // Valid data takes precedence over a timeout in the same cycle.
                if (avl_readdatavalid) begin
                    rdata_d = avl_readdata;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = TIMEOUT_DATA;
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (grant_q == PTR_W'(N_PORTS - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_q + 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction without acknowledging it.
    always_ff @(posedge external_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            cmd_q   <= 1'b0;
            burst_q <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            cmd_q   <= cmd_d;
            burst_q <= burst_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    // Acknowledge is a decode of the DONE state, so it lasts exactly one cycle.
    always_comb begin
        p_ack = '0;
        if (state_q == S_DONE) begin
            p_ack[grant_q] = 1'b1;
        end
    end

    assign p_rdata        = rdata_q;
    assign avl_address    = addr_q;
    assign avl_writedata  = wdata_q;
    assign avl_read       = cmd_q & ~is_wr_q;
    assign avl_write      = cmd_q & is_wr_q;
    assign avl_burstbegin = burst_q;
    assign timeout_err    = terr_q;
    assign state          = state_q;

endmodule

// File: tb/tb_avl_mem_arbiter.sv
// tb_avl_mem_arbiter
// Directed bench for avl_mem_arbiter (2 ports, read timeout 16 cycles).
// Stimulus tasks queue the expected acknowledge; an independent monitor pops
// and compares whenever p_ack is seen. A small controller model answers the
// Avalon side with programmable waitrequest and read-data delays.
module tb_avl_mem_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int VW = 27;
    localparam int DW = 32;
    localparam int TO = 16;

    logic                 external_clk = 1'b0;
    logic                 rst;
    logic                 init_done;
    logic [NP-1:0]        p_rreq;
    logic [NP-1:0]        p_wreq;
    logic [NP*AW-1:0]     p_addr;
    logic [NP*DW-1:0]     p_wdata;
    logic [DW-1:0]        p_rdata;
    logic [NP-1:0]        p_ack;
    logic                 avl_waitrequest_n;
    logic [VW-1:0]        avl_address;
    logic [DW-1:0]        avl_writedata;
    logic                 avl_read;
    logic                 avl_write;
    logic                 avl_burstbegin;
    logic                 avl_readdatavalid;
    logic [DW-1:0]        avl_readdata;
    logic                 timeout_err;
    logic [1:0]           state;

    avl_mem_arbiter #(
        .N_PORTS(NP), .CPU_ADDR_W(AW), .AVL_ADDR_W(VW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .external_clk(external_clk), .rst(rst), .init_done(init_done),
        .p_rreq(p_rreq), .p_wreq(p_wreq), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ack(p_ack),
        .avl_waitrequest_n(avl_waitrequest_n), .avl_address(avl_address),
        .avl_writedata(avl_writedata), .avl_read(avl_read), .avl_write(avl_write),
        .avl_burstbegin(avl_burstbegin), .avl_readdatavalid(avl_readdatavalid),
        .avl_readdata(avl_readdata), .timeout_err(timeout_err), .state(state)
    );

    always #5 external_clk = ~external_clk;

    typedef struct {
        int          port;
        bit          isRead;
        logic [31:0] data;
        bit          terr;
    } exp_t;

    exp_t        expQ[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cycleCnt = 0;

    // Controller model knobs and observations
    int          waitLo = 0;
    int          rdDelay = 0;
    logic [31:0] rdData = '0;
    int          waitCnt = 0;
    int          rdCnt = 0;
    bit          rdPending = 1'b0;
    int          cmdRd = 0;
    int          cmdWr = 0;
    int          burstHigh = 0;
    int          waitRdCycles = 0;
    logic [VW-1:0] lastAddr = '0;
    logic [31:0] lastWdata = '0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearObs();
        cmdRd = 0;
        cmdWr = 0;
        burstHigh = 0;
        waitRdCycles = 0;
    endtask

    // Issues one request, waits (bounded) for its ack, then drops the request.
    task automatic applyStimulus(input int port, input bit isWr, input bit alsoRead,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expData, input bit expTerr,
                                 output int latency);
        exp_t e;
        int   start;
        bit   seen;
        e.port = port;
        e.isRead = !isWr;
        e.data = expData;
        e.terr = expTerr;
        expQ.push_back(e);
        @(posedge external_clk);
        #1;
        p_addr[port*AW +: AW] = addr;
        p_wdata[port*DW +: DW] = wdata;
        if (isWr) p_wreq[port] = 1'b1;
        if (!isWr || alsoRead) p_rreq[port] = 1'b1;
        start = cycleCnt;
        seen = 1'b0;
        latency = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge external_clk);
            if (p_ack[port]) begin
                seen = 1'b1;
                latency = cycleCnt - start;
                break;
            end
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL ack_wait: port %0d got no ack in 200 cycles, expected one", port);
        end
        @(posedge external_clk);
        #1;
        p_wreq[port] = 1'b0;
        p_rreq[port] = 1'b0;
    endtask

    initial forever begin
        @(posedge external_clk);
        cycleCnt++;
    end

    // Avalon controller model, decisions made on the falling edge
    initial forever begin
        @(negedge external_clk);
        avl_readdatavalid = 1'b0;
        if (rst) begin
            waitCnt = 0;
            rdPending = 1'b0;
            avl_waitrequest_n = 1'b1;
        end else begin
            if (state == 2'd2) waitRdCycles++;
            if (avl_read) cmdRd++;
            if (avl_write) cmdWr++;
            if (avl_burstbegin) burstHigh++;
            if (rdPending) begin
                rdCnt++;
                if (rdDelay != 0 && rdCnt == rdDelay) begin
                    avl_readdatavalid = 1'b1;
                    avl_readdata = rdData;
                    rdPending = 1'b0;
                end
            end
            if (avl_read || avl_write) begin
                if (waitCnt < waitLo) begin
                    avl_waitrequest_n = 1'b0;
                    waitCnt++;
                end else begin
                    avl_waitrequest_n = 1'b1;
                    waitCnt = 0;
                    lastAddr = avl_address;
                    lastWdata = avl_writedata;
                    if (avl_read) begin
                        rdPending = 1'b1;
                        rdCnt = 0;
                    end
                end
            end else begin
                avl_waitrequest_n = 1'b1;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        exp_t          e;
        logic [NP-1:0] ea;
        forever begin
            @(negedge external_clk);
            if (!rst && p_ack != '0) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_ack: got p_ack=0x%0h, expected none", p_ack);
                end else begin
                    e = expQ.pop_front();
                    ea = '0;
                    ea[e.port] = 1'b1;
                    checkOutput("ack_port", 64'(p_ack), 64'(ea));
                    if (e.isRead) checkOutput("rdata", 64'(p_rdata), 64'(e.data));
                    checkOutput("ack_timeout_err", 64'(timeout_err), 64'(e.terr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at 200000 ns, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int acks;
        rst = 1'b1;
        init_done = 1'b1;
        p_rreq = '0;
        p_wreq = '0;
        p_addr = '0;
        p_wdata = '0;
        avl_waitrequest_n = 1'b1;
        avl_readdatavalid = 1'b0;
        avl_readdata = '0;

        // Reset state
        repeat (3) @(posedge external_clk);
        @(negedge external_clk);
        checkOutput("rst_state", 64'(state), 64'd0);
        checkOutput("rst_ack", 64'(p_ack), 64'd0);
        checkOutput("rst_cmd", 64'({avl_read, avl_write, avl_burstbegin}), 64'd0);
        checkOutput("rst_terr", 64'(timeout_err), 64'd0);
        checkOutput("rst_rdata", 64'(p_rdata), 64'd0);
        checkOutput("rst_addr", 64'(avl_address), 64'd0);
        @(posedge external_clk);
        #1;
        rst = 1'b0;

        // Write port 0, zero-wait controller
        clearObs();
        waitLo = 0;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1'b0, lat);
        checkOutput("wr_latency", 64'(lat), 64'd3);
        checkOutput("wr_addr", 64'(lastAddr), 64'd4);
        checkOutput("wr_data", 64'(lastWdata), 64'hCAFE_F00D);
        checkOutput("wr_cmd_cycles", 64'(cmdWr), 64'd1);
        checkOutput("wr_burst_cycles", 64'(burstHigh), 64'd1);

        // Read port 1, data five cycles after acceptance
        clearObs();
        rdDelay = 5;
        rdData = 32'h1234_5678;
        applyStimulus(1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 1'b0, lat);
        checkOutput("rd_addr", 64'(lastAddr), 64'h40);
        checkOutput("rd_latency", 64'(lat), 64'd8);

        // Both ports requesting continuously: grants must alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.port = i % 2;
            e.isRead = 1'b0;
            e.data = 32'h0;
            e.terr = 1'b0;
            expQ.push_back(e);
        end
        @(posedge external_clk);
        #1;
        p_addr = {32'h0000_0300, 32'h0000_0200};
        p_wdata = {32'h1111_1111, 32'h0000_0000};
        p_wreq = 2'b11;
        acks = 0;
        for (int i = 0; i < 100 && acks < 4; i++) begin
            @(negedge external_clk);
            if (p_ack != '0) acks++;
        end
        @(posedge external_clk);
        #1;
        p_wreq = '0;
        checkOutput("rr_ack_count", 64'(acks), 64'd4);

        // Read that never gets data: times out after TO WAIT_RD cycles
        clearObs();
        rdDelay = 0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 1'b1, lat);
        checkOutput("to_wait_cycles", 64'(waitRdCycles), 64'd16);
        checkOutput("to_err_sticky", 64'(timeout_err), 64'd1);

        // Late data arriving after timeout must be discarded
        rdDelay = 20;
        rdData = 32'h5555_AAAA;
        applyStimulus(0, 1'b0, 1'b0, 32'h0000_0024, 32'h0, 32'hDEAD_BEEF, 1'b1, lat);
        repeat (10) @(negedge external_clk);
        checkOutput("late_rdata_held", 64'(p_rdata), 64'hDEAD_BEEF);
        checkOutput("late_state_idle", 64'(state), 64'd0);

        // waitrequest low 7 cycles: read held 8 cycles, burstbegin once
        clearObs();
        waitLo = 7;
        rdDelay = 2;
        rdData = 32'hA5A5_0001;
        applyStimulus(1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'hA5A5_0001, 1'b1, lat);
        checkOutput("ws_cmd_cycles", 64'(cmdRd), 64'd8);
        checkOutput("ws_burst_cycles", 64'(burstHigh), 64'd1);
        waitLo = 0;

        // Reset during WAIT_RD: no ack, everything back to zero
        rdDelay = 0;
        @(posedge external_clk);
        #1;
        p_addr[0 +: AW] = 32'h0000_0030;
        p_rreq[0] = 1'b1;
        for (int i = 0; i < 20 && state != 2'd2; i++) @(negedge external_clk);
        checkOutput("mid_reach_wait", 64'(state), 64'd2);
        repeat (2) @(posedge external_clk);
        #1;
        rst = 1'b1;
        init_done = 1'b0;
        p_rreq = '0;
        @(posedge external_clk);
        @(negedge external_clk);
        checkOutput("mid_rst_state", 64'(state), 64'd0);
        checkOutput("mid_rst_cmd", 64'({avl_read, avl_write, avl_burstbegin}), 64'd0);
        checkOutput("mid_rst_ack", 64'(p_ack), 64'd0);
        checkOutput("mid_rst_terr", 64'(timeout_err), 64'd0);
        @(posedge external_clk);
        #1;
        rst = 1'b0;

        // init_done low blocks a pending request
        p_addr[AW +: AW] = 32'h0000_0080;
        p_rreq[1] = 1'b1;
        repeat (6) @(negedge external_clk);
        checkOutput("init_block_state", 64'(state), 64'd0);
        @(posedge external_clk);
        #1;
        p_rreq = '0;
        init_done = 1'b1;
        rdDelay = 3;
        rdData = 32'h0BAD_CAFE;
        applyStimulus(1, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h0BAD_CAFE, 1'b0, lat);
        checkOutput("init_rd_addr", 64'(lastAddr), 64'h20);

        // Read and write together on one port: only the write is performed
        clearObs();
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0044, 32'h1122_3344, 32'h0, 1'b0, lat);
        checkOutput("both_wr_cycles", 64'(cmdWr), 64'd1);
        checkOutput("both_rd_cycles", 64'(cmdRd), 64'd0);
        checkOutput("both_wdata", 64'(lastWdata), 64'h1122_3344);

        repeat (5) @(negedge external_clk);
        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
